// File: rtl/program_loader.sv
// Boots the CPU from a UART byte stream: a little-endian word count, N instruction words,
// then an optional checksum word when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  rom_wren,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [31:0]           rom_write_data,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_SIZE, S_DATA, S_CSUM, S_DONE, S_ERROR} state_e;
  localparam state_e PostData = S_CSUM;
`else
  typedef enum logic [2:0] {S_SIZE, S_DATA, S_DONE, S_ERROR} state_e;
  localparam state_e PostData = S_DONE;
`endif

  localparam logic [32:0] MaxWords = 33'(1) << ADDR_WIDTH;

  state_e                state_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           word_buf_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic [ADDR_WIDTH:0]   word_idx_q;
  logic                  rom_wren_q;
  logic [ADDR_WIDTH-1:0] rom_address_q;
  logic [31:0]           rom_write_data_q;
  logic                  cpu_reset_n_q;
  logic                  done_q;
  logic                  error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q;
`endif

  logic                  accept_d;
  logic                  word_full_d;
  logic [31:0]           word_d;
  logic [ADDR_WIDTH:0]   idx_next_d;

  always_comb begin
    rx_ready = (state_q == S_SIZE) || (state_q == S_DATA)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               || (state_q == S_CSUM)
`endif
               ;
    accept_d    = rx_valid && rx_ready;
    word_full_d = accept_d && (byte_cnt_q == 2'd3);
    word_d      = {rx_data, word_buf_q};
    idx_next_d  = word_idx_q + (ADDR_WIDTH+1)'(1);
  end

  // The fourth byte is never buffered; it completes word_d directly on the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_SIZE;
      byte_cnt_q       <= 2'd0;
      word_buf_q       <= '0;
      word_cnt_q       <= '0;
      word_idx_q       <= '0;
      rom_wren_q       <= 1'b0;
      rom_address_q    <= '0;
      rom_write_data_q <= '0;
      cpu_reset_n_q    <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q            <= '0;
`endif
    end else begin
      rom_wren_q <= 1'b0;
      if (accept_d) begin
        case (byte_cnt_q)
          2'd0:    word_buf_q[7:0]   <= rx_data;
          2'd1:    word_buf_q[15:8]  <= rx_data;
          2'd2:    word_buf_q[23:16] <= rx_data;
          default: ;
        endcase
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      case (state_q)
        S_SIZE: begin
          if (word_full_d) begin
            if (word_d == 32'd0) begin
              state_q <= PostData;
            end else if ({1'b0, word_d} > MaxWords) begin
              state_q <= S_ERROR;
            end else begin
              word_cnt_q <= word_d[ADDR_WIDTH:0];
              word_idx_q <= '0;
              state_q    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_full_d) begin
            rom_wren_q       <= 1'b1;
            rom_address_q    <= word_idx_q[ADDR_WIDTH-1:0];
            rom_write_data_q <= word_d;
            word_idx_q       <= idx_next_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q            <= sum_q + word_d;
`endif
            if (idx_next_d == word_cnt_q) begin
              state_q <= PostData;
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (word_full_d) begin
            state_q <= (word_d == sum_q) ? S_DONE : S_ERROR;
          end
        end
`endif
        // Status flags follow the state by one cycle so done trails the last write pulse.
        S_DONE: begin
          done_q        <= 1'b1;
          cpu_reset_n_q <= 1'b1;
        end
        S_ERROR: begin
          error_q       <= 1'b1;
          cpu_reset_n_q <= 1'b0;
        end
        default: state_q <= S_ERROR;
      endcase
    end
  end

  assign rom_wren       = rom_wren_q;
  assign rom_address    = rom_address_q;
  assign rom_write_data = rom_write_data_q;
  assign cpu_reset_n    = cpu_reset_n_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected ROM writes are queued as words are streamed
// and checked by a monitor; PROGRAM_LOADER_CHECKSUM_EN adds the checksum scenarios.
module tb_program_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          rom_wren;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_write_data;
  logic          cpu_reset_n;
  logic          done;
  logic          error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           exp_w;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            cyc = 0;
  int            last_wren_cyc = -1;
  int            wr_count = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   tb_sum = 32'd0;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rom_wren       (rom_wren),
    .rom_address    (rom_address),
    .rom_write_data (rom_write_data),
    .cpu_reset_n    (cpu_reset_n),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every write pulse is matched against the oldest expected write, and the CPU must still be held.
  always @(negedge clk) begin
    if (reset_n && rom_wren) begin
      wr_count++;
      last_wren_cyc = cyc;
      last_addr = rom_address;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got addr=%h data=%h, required no write", rom_address, rom_write_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (rom_address !== exp_w.addr || rom_write_data !== exp_w.data) begin
          tests_failed++;
          $display("[TB] FAIL write_value: got (%h,%h), required (%h,%h)", rom_address, rom_write_data, exp_w.addr, exp_w.data);
        end
      end
      tests_run++;
      if (done !== 1'b0 || cpu_reset_n !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL early_release: got done=%b cpu_reset_n=%b during write, required 0/0", done, cpu_reset_n);
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    tb_sum = 32'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      ok = rx_ready;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL byte_accept: got rx_ready=0 for 50 cycles, required 1 (byte %h)", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic push_data(input logic [AW-1:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
    tb_sum = tb_sum + w;
  endtask

  task automatic send_csum(input bit gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_word(tb_sum, gap);
`else
    if (gap) @(negedge clk);
`endif
  endtask

  task automatic idle;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL done_timeout: got done=%b after 50 cycles, required 1", done);
    end
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_missing_writes: got %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #7;
    tests_run++;
    if (rom_wren !== 1'b0 || rom_address !== '0 || rom_write_data !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rom: got wren=%b addr=%h data=%h, required 0/0/0", rom_wren, rom_address, rom_write_data);
    end
    tests_run++;
    if (cpu_reset_n !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got cpu_reset_n=%b done=%b error=%b, required 0/0/0", cpu_reset_n, done, error);
    end
    tests_run++;
    if (rx_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got rx_ready=%b, required 1", rx_ready);
    end
    do_reset();
  endtask

  task automatic test_back_to_back;
    int dc;
    do_reset();
    push_data(0, 32'h0000_0013);
    push_data(1, 32'h0010_0093);
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    send_csum(1'b0);
    idle();
    wait_done(dc);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    tests_run++;
    if (dc != last_wren_cyc + 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done_latency: got done at cycle %0d, required %0d", dc, last_wren_cyc + 1);
    end
`endif
    tests_run++;
    if (cpu_reset_n !== 1'b1 || error !== 1'b0 || rx_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_status: got cpu_reset_n=%b error=%b rx_ready=%b, required 1/0/0", cpu_reset_n, error, rx_ready);
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_word;
    int dc;
    do_reset();
    send_word(32'd2, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (rom_wren !== 1'b0 || rom_address !== '0 || rom_write_data !== 32'd0 ||
        cpu_reset_n !== 1'b0 || done !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midword_reset: got wren=%b addr=%h data=%h cpu_reset_n=%b done=%b error=%b ready=%b, required 0/0/0/0/0/0/1",
               rom_wren, rom_address, rom_write_data, cpu_reset_n, done, error, rx_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tb_sum = 32'd0;
    push_data(0, 32'h0000_0013);
    push_data(1, 32'h0010_0093);
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    send_csum(1'b0);
    idle();
    wait_done(dc);
    tests_run++;
    if (cpu_reset_n !== 1'b1 || error !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midword_reload: got cpu_reset_n=%b error=%b, required 1/0", cpu_reset_n, error);
    end
    check_drained("midword");
  endtask

  task automatic test_n_zero;
    int dc;
    int w0;
    do_reset();
    w0 = wr_count;
    send_word(32'd0, 1'b0);
    send_csum(1'b0);
    idle();
    wait_done(dc);
    tests_run++;
    if (cpu_reset_n !== 1'b1 || error !== 1'b0 || wr_count != w0) begin
      tests_failed++;
      $display("[TB] FAIL nzero: got cpu_reset_n=%b error=%b writes=%0d, required 1/0/0", cpu_reset_n, error, wr_count - w0);
    end
  endtask

  task automatic test_overflow;
    int dc;
    int w0;
    logic [31:0] w;
    do_reset();
    w0 = wr_count;
    send_word(32'h0000_0401, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    tests_run++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_reset_n !== 1'b0 || done !== 1'b0 || wr_count != w0) begin
      tests_failed++;
      $display("[TB] FAIL overflow: got error=%b ready=%b cpu_reset_n=%b done=%b writes=%0d, required 1/0/0/0/0",
               error, rx_ready, cpu_reset_n, done, wr_count - w0);
    end
    do_reset();
    w0 = wr_count;
    send_word(32'h0000_0400, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      w = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      push_data(i[AW-1:0], w);
      send_word(w, 1'b0);
    end
    send_csum(1'b0);
    idle();
    wait_done(dc);
    tests_run++;
    if (wr_count - w0 != 1024 || last_addr !== 10'h3FF) begin
      tests_failed++;
      $display("[TB] FAIL full_fill: got %0d writes last addr %h, required 1024 writes last addr 3ff", wr_count - w0, last_addr);
    end
    tests_run++;
    if (cpu_reset_n !== 1'b1 || error !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_fill_status: got cpu_reset_n=%b error=%b, required 1/0", cpu_reset_n, error);
    end
    check_drained("full_fill");
  endtask

  task automatic test_gapped;
    int dc;
    int w0;
    do_reset();
    push_data(0, 32'h0000_0013);
    push_data(1, 32'h0010_0093);
    send_word(32'd2, 1'b1);
    send_word(32'h0000_0013, 1'b1);
    send_word(32'h0010_0093, 1'b1);
    send_csum(1'b1);
    idle();
    wait_done(dc);
    check_drained("gapped");
    w0 = wr_count;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx_valid = i[0];
      rx_data  = 8'($urandom_range(0, 255));
    end
    idle();
    repeat (2) @(negedge clk);
    tests_run++;
    if (wr_count != w0 || done !== 1'b1 || error !== 1'b0 || cpu_reset_n !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL after_done_ignore: got writes=%0d done=%b error=%b cpu_reset_n=%b, required 0/1/0/1",
               wr_count - w0, done, error, cpu_reset_n);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int dc;
    bit seen;
    do_reset();
    push_data(0, 32'h0000_0013);
    push_data(1, 32'h0010_0093);
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    send_word(32'h0010_00A6, 1'b0);
    idle();
    wait_done(dc);
    tests_run++;
    if (done !== 1'b1 || error !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL csum_match: got done=%b error=%b, required 1/0", done, error);
    end
    check_drained("csum_match");
    do_reset();
    push_data(0, 32'h0000_0013);
    push_data(1, 32'h0010_0093);
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    send_word(32'h0010_00A7, 1'b0);
    idle();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (error === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen || done !== 1'b0 || cpu_reset_n !== 1'b0 || rx_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL csum_mismatch: got error=%b done=%b cpu_reset_n=%b ready=%b, required 1/0/0/0",
               error, done, cpu_reset_n, rx_ready);
    end
    check_drained("csum_mismatch");
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_reset_mid_word();
    test_n_zero();
    test_overflow();
    test_gapped();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
